wb_stage: RTL and testbench

- Write-back pipeline stage of the 5-stage MIPS core; last stage before the GPR file.
- Accepts one instruction per handshake from the MEM stage and holds it in a stage register.
- Extracts and aligns load data (LB/LBU/LH/LHU/LW/LWL/LWR) and drives the register-file write port (4-bit byte enables, address, data).
- Exports forwarding/hazard info to the decode stage.

---
 rtl/wb_stage_if.sv | 25 ++
 rtl/wb_stage.sv | 190 +++++++++++++++++++
 tb/tb_wb_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM-to-WB instruction handoff bus: MEM drives the offer and payload,
// and WB answers with ws_allowin.
interface wb_stage_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gpr_we;
  logic [4:0]  ms_dest;
  logic [2:0]  ms_ld_op;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_result;
  logic [31:0] ms_rdata;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gpr_we, ms_dest, ms_ld_op,
           ms_addr_lo, ms_result, ms_rdata,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gpr_we, ms_dest, ms_ld_op,
           ms_addr_lo, ms_result, ms_rdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, aligns load data and drives the GPR write port.
// Optional reference-trace ports are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_stall,
  wb_stage_if.slave   ms,
  output logic [3:0]  reg_wen,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic        ws_fwd_partial
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  typedef struct packed {
    logic          gpr_we;
    logic [AW-1:0] dest;
    logic [2:0]    ld_op;
    logic [1:0]    addr_lo;
    logic [DW-1:0] result;
    logic [DW-1:0] rdata;
  } ws_inst_t;

  logic     ws_valid_q;
  ws_inst_t inst_q;
  ws_inst_t inst_d;
  logic     ws_ready_go;
  logic     ws_allowin;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_data;
  logic [3:0]    wen_mask;
  logic          fwd_valid_c;
  logic          do_write_c;

  assign ws_ready_go   = !ws_stall;
  assign ws_allowin    = !ws_valid_q || ws_ready_go;
  assign ms.ws_allowin = ws_allowin;

  assign inst_d = '{
    gpr_we:  ms.ms_gpr_we,
    dest:    ms.ms_dest,
    ld_op:   ms.ms_ld_op,
    addr_lo: ms.ms_addr_lo,
    result:  ms.ms_result,
    rdata:   ms.ms_rdata
  };

  // Stage register: refills on any cycle the previous instruction retires.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      inst_q     <= '0;
    end else begin
      if (ws_allowin) begin
        ws_valid_q <= ms.ms_to_ws_valid;
      end
      if (ws_allowin && ms.ms_to_ws_valid) begin
        inst_q <= inst_d;
      end
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  logic [DW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q <= PC_RESET;
    end else if (ws_allowin && ms.ms_to_ws_valid) begin
      pc_q <= ms.ms_pc;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{ms.ms_pc, PC_RESET};
`endif

  // Load alignment; LWL/LWR produce a partial-word merge mask.
  always_comb begin
    byte_sel  = '0;
    half_sel  = '0;
    load_data = inst_q.result;
    wen_mask  = 4'hf;

    case (inst_q.addr_lo)
      2'd0:    byte_sel = inst_q.rdata[7:0];
      2'd1:    byte_sel = inst_q.rdata[15:8];
      2'd2:    byte_sel = inst_q.rdata[23:16];
      default: byte_sel = inst_q.rdata[31:24];
    endcase
    half_sel = inst_q.addr_lo[1] ? inst_q.rdata[31:16] : inst_q.rdata[15:0];

    case (inst_q.ld_op)
      LD_NONE: load_data = inst_q.result;
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'h0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'h0, half_sel};
      LD_LW:   load_data = inst_q.rdata;
      LD_LWL: begin
        case (inst_q.addr_lo)
          2'd0: begin
            load_data = {inst_q.rdata[7:0], 24'h0};
            wen_mask  = 4'b1000;
          end
          2'd1: begin
            load_data = {inst_q.rdata[15:0], 16'h0};
            wen_mask  = 4'b1100;
          end
          2'd2: begin
            load_data = {inst_q.rdata[23:0], 8'h0};
            wen_mask  = 4'b1110;
          end
          default: begin
            load_data = inst_q.rdata;
            wen_mask  = 4'b1111;
          end
        endcase
      end
      LD_LWR: begin
        case (inst_q.addr_lo)
          2'd0: begin
            load_data = inst_q.rdata;
            wen_mask  = 4'b1111;
          end
          2'd1: begin
            load_data = {8'h0, inst_q.rdata[31:8]};
            wen_mask  = 4'b0111;
          end
          2'd2: begin
            load_data = {16'h0, inst_q.rdata[31:16]};
            wen_mask  = 4'b0011;
          end
          default: begin
            load_data = {24'h0, inst_q.rdata[31:24]};
            wen_mask  = 4'b0001;
          end
        endcase
      end
      default: load_data = inst_q.result;
    endcase
  end

  // Reset gating keeps a write from escaping in the cycle that drops the instruction.
  assign fwd_valid_c = ws_valid_q && inst_q.gpr_we && (inst_q.dest != '0);
  assign do_write_c  = fwd_valid_c && ws_ready_go && resetn;

  assign reg_wen        = do_write_c ? wen_mask : 4'h0;
  assign reg_waddr      = ws_valid_q ? inst_q.dest : '0;
  assign reg_wdata      = ws_valid_q ? load_data : '0;
  assign ws_fwd_valid   = fwd_valid_c;
  assign ws_fwd_dest    = fwd_valid_c ? inst_q.dest : '0;
  assign ws_fwd_data    = reg_wdata;
  assign ws_fwd_partial = fwd_valid_c
                          && ((inst_q.ld_op == LD_LWL) || (inst_q.ld_op == LD_LWR))
                          && (wen_mask != 4'hf);

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = reg_wen;
  assign debug_wb_rf_wnum  = reg_waddr;
  assign debug_wb_rf_wdata = reg_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: per-cycle compare against a behavioural model,
// directed literal cases, then randomized traffic with stalls and resets.
module tb_wb_stage;
  localparam logic [31:0] PC_RST = 32'hbfc0_0000;

  logic clk = 1'b0;
  logic resetn;
  logic ws_stall;
  logic [3:0]  reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic        ws_fwd_partial;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_stage_if ms_if ();

  wb_stage #(.PC_RESET(PC_RST)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_stall       (ws_stall),
    .ms             (ms_if.slave),
    .reg_wen        (reg_wen),
    .reg_waddr      (reg_waddr),
    .reg_wdata      (reg_wdata),
    .ws_fwd_valid   (ws_fwd_valid),
    .ws_fwd_dest    (ws_fwd_dest),
    .ws_fwd_data    (ws_fwd_data),
    .ws_fwd_partial (ws_fwd_partial)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  // Model of the held instruction
  logic        m_valid = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [2:0]  m_op = '0;
  logic [1:0]  m_n = '0;
  logic [31:0] m_result = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_pc = PC_RST;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_data(input logic [2:0] op, input logic [1:0] n,
                                         input logic [31:0] res, input logic [31:0] rd);
    int ni;
    logic [31:0] b;
    logic [31:0] h;
    ni = int'(n);
    b = (rd >> (8 * ni)) & 32'h0000_00ff;
    h = (rd >> (16 * (ni / 2))) & 32'h0000_ffff;
    case (op)
      3'd0: return res;
      3'd1: return b[7] ? (b | 32'hffff_ff00) : b;
      3'd2: return b;
      3'd3: return h[15] ? (h | 32'hffff_0000) : h;
      3'd4: return h;
      3'd5: return rd;
      3'd6: return rd << (8 * (3 - ni));
      default: return rd >> (8 * ni);
    endcase
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [1:0] n);
    int ni;
    ni = int'(n);
    if (op == 3'd6) return 4'(4'hf << (3 - ni));
    if (op == 3'd7) return 4'(4'hf >> ni);
    return 4'hf;
  endfunction

  task automatic compare_all();
    logic        fv;
    logic [3:0]  ew;
    logic [31:0] ed;
    fv = m_valid && m_we && (m_dest != 5'd0);
    ew = (fv && !ws_stall && resetn) ? m_mask(m_op, m_n) : 4'h0;
    ed = m_valid ? m_data(m_op, m_n, m_result, m_rdata) : 32'h0;
    check("allowin", 32'(ms_if.ws_allowin), 32'(!m_valid || !ws_stall));
    check("reg_wen", 32'(reg_wen), 32'(ew));
    check("reg_waddr", 32'(reg_waddr), m_valid ? 32'(m_dest) : 32'h0);
    check("reg_wdata", reg_wdata, ed);
    check("fwd_valid", 32'(ws_fwd_valid), 32'(fv));
    check("fwd_dest", 32'(ws_fwd_dest), fv ? 32'(m_dest) : 32'h0);
    check("fwd_data", ws_fwd_data, ed);
    check("fwd_partial", 32'(ws_fwd_partial),
          32'(fv && (m_op >= 3'd6) && (m_mask(m_op, m_n) != 4'hf)));
`ifdef WB_DEBUG_TRACE_EN
    check("dbg_pc", debug_wb_pc, m_pc);
    check("dbg_wen", 32'(debug_wb_rf_wen), 32'(ew));
    check("dbg_wnum", 32'(debug_wb_rf_wnum), m_valid ? 32'(m_dest) : 32'h0);
    check("dbg_wdata", debug_wb_rf_wdata, ed);
`endif
    if (reg_wen != 4'h0) wr_cnt++;
  endtask

  // Called at a negedge: compare, then advance model across the next posedge.
  task automatic finish_step();
    compare_all();
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_we = 1'b0; m_dest = '0; m_op = '0; m_n = '0;
      m_result = '0; m_rdata = '0; m_pc = PC_RST;
    end else if (!m_valid || !ws_stall) begin
      if (ms_if.ms_to_ws_valid) begin
        m_we = ms_if.ms_gpr_we; m_dest = ms_if.ms_dest; m_op = ms_if.ms_ld_op;
        m_n = ms_if.ms_addr_lo; m_result = ms_if.ms_result; m_rdata = ms_if.ms_rdata;
        m_pc = ms_if.ms_pc;
      end
      m_valid = ms_if.ms_to_ws_valid;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    finish_step();
  endtask

  task automatic offer(input logic v, input logic we, input logic [4:0] dest,
                       input logic [2:0] op, input logic [1:0] n,
                       input logic [31:0] res, input logic [31:0] rd, input logic [31:0] pc);
    ms_if.ms_to_ws_valid = v;
    ms_if.ms_gpr_we = we;
    ms_if.ms_dest = dest;
    ms_if.ms_ld_op = op;
    ms_if.ms_addr_lo = n;
    ms_if.ms_result = res;
    ms_if.ms_rdata = rd;
    ms_if.ms_pc = pc;
  endtask

  task automatic ld_case(input string name, input logic [2:0] op, input logic [1:0] n,
                         input logic [31:0] rd, input logic [3:0] ew,
                         input logic [31:0] ed, input logic ep);
    offer(1'b1, 1'b1, 5'd7, op, n, 32'h0, rd, 32'h0000_1000);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check({name, "_wen"}, 32'(reg_wen), 32'(ew));
    check({name, "_wdata"}, reg_wdata, ed);
    check({name, "_partial"}, 32'(ws_fwd_partial), 32'(ep));
    finish_step();
  endtask

  initial begin
    int w0;
    resetn = 1'b0;
    ws_stall = 1'b0;
    offer(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    check("rst_allowin", 32'(ms_if.ws_allowin), 32'd1);
    check("rst_wen", 32'(reg_wen), 32'd0);
    check("rst_fwd_valid", 32'(ws_fwd_valid), 32'd0);
`ifdef WB_DEBUG_TRACE_EN
    check("rst_dbg_pc", debug_wb_pc, 32'hbfc0_0000);
`endif
    finish_step();
    resetn = 1'b1;
    step();

    // ALU result write
    offer(1'b1, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'hbfc0_0004);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("alu_wen", 32'(reg_wen), 32'hf);
    check("alu_waddr", 32'(reg_waddr), 32'd5);
    check("alu_wdata", reg_wdata, 32'h1234_5678);
    check("alu_fwd_valid", 32'(ws_fwd_valid), 32'd1);
    finish_step();

    ld_case("lb3",  3'd1, 2'd3, 32'h80ff_7f01, 4'hf, 32'hffff_ff80, 1'b0);
    ld_case("lbu2", 3'd2, 2'd2, 32'h80ff_7f01, 4'hf, 32'h0000_00ff, 1'b0);
    ld_case("lh2",  3'd3, 2'd2, 32'h80ff_7f01, 4'hf, 32'hffff_80ff, 1'b0);
    ld_case("lhu0", 3'd4, 2'd0, 32'h80ff_7f01, 4'hf, 32'h0000_7f01, 1'b0);
    ld_case("lwl1", 3'd6, 2'd1, 32'haabb_ccdd, 4'b1100, 32'hccdd_0000, 1'b1);
    ld_case("lwr2", 3'd7, 2'd2, 32'haabb_ccdd, 4'b0011, 32'h0000_aabb, 1'b1);
    ld_case("lwr0", 3'd7, 2'd0, 32'haabb_ccdd, 4'b1111, 32'haabb_ccdd, 1'b0);
    ld_case("lwl3", 3'd6, 2'd3, 32'haabb_ccdd, 4'b1111, 32'haabb_ccdd, 1'b0);

    // Three-cycle stall with the next instruction waiting upstream
    offer(1'b1, 1'b1, 5'd9, 3'd0, 2'd0, 32'h0000_00aa, 32'h0, 32'h0000_2000);
    step();
    offer(1'b1, 1'b1, 5'd10, 3'd0, 2'd0, 32'h0000_00bb, 32'h0, 32'h0000_2004);
    ws_stall = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_allowin", 32'(ms_if.ws_allowin), 32'd0);
      check("stall_wen", 32'(reg_wen), 32'd0);
      check("stall_wdata", reg_wdata, 32'h0000_00aa);
      finish_step();
    end
    ws_stall = 1'b0;
    @(negedge clk);
    check("release_wen", 32'(reg_wen), 32'hf);
    check("release_wdata", reg_wdata, 32'h0000_00aa);
    finish_step();
    ms_if.ms_to_ws_valid = 1'b0;
    check("stall_write_count", 32'(wr_cnt - w0), 32'd1);
    @(negedge clk);
    check("next_wdata", reg_wdata, 32'h0000_00bb);
    check("next_waddr", 32'(reg_waddr), 32'd10);
    finish_step();

    // Writes to $zero are suppressed
    offer(1'b1, 1'b1, 5'd0, 3'd0, 2'd0, 32'hdead_beef, 32'h0, 32'h0);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    check("r0_wen", 32'(reg_wen), 32'd0);
    check("r0_fwd_valid", 32'(ws_fwd_valid), 32'd0);
    finish_step();

    // Reset over a stalled instruction
    offer(1'b1, 1'b1, 5'd3, 3'd0, 2'd0, 32'h0bad_f00d, 32'h0, 32'h0);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    ws_stall = 1'b1;
    step();
    resetn = 1'b0;
    @(negedge clk);
    check("rststall_wen", 32'(reg_wen), 32'd0);
    finish_step();
    resetn = 1'b1;
    ws_stall = 1'b0;
    @(negedge clk);
    check("rststall_after_wen", 32'(reg_wen), 32'd0);
    check("rststall_after_fwd", 32'(ws_fwd_valid), 32'd0);
    check("rststall_after_allowin", 32'(ms_if.ws_allowin), 32'd1);
    finish_step();

    // Reset in a cycle that would otherwise write
    offer(1'b1, 1'b1, 5'd4, 3'd0, 2'd0, 32'h5555_aaaa, 32'h0, 32'h0);
    step();
    ms_if.ms_to_ws_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("rstgo_wen", 32'(reg_wen), 32'd0);
    finish_step();
    resetn = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      offer($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      ws_stall = ($urandom_range(0, 3) == 0);
      resetn = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
